led: RTL and testbench



---
 rtl/led.sv | 57 +++++
 tb/tb_led.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/led.sv
// Memory-mapped LED output peripheral.
// Two write-only byte registers at BASE_ADDR (low byte) and BASE_ADDR+1
// (high byte, 8-bit wrap) drive 16 board LEDs. The block only samples the
// bus; it never drives it and has no read path.
module led #(
    parameter logic [7:0] BASE_ADDR = 8'hC0
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] BUS_ADDR,
    input  logic [7:0] BUS_DATA,
    input  logic       BUS_WE,
    output logic [7:0] LEDH,
    output logic [7:0] LEDL
);

    // High-byte address. Declaring it as an 8-bit value makes BASE_ADDR 8'hFF
    // place the high register at 8'h00.
    localparam logic [7:0] HIGH_ADDR = BASE_ADDR + 8'd1;

    logic       sel_low;
    logic       sel_high;
    logic [7:0] reg_l;
    logic [7:0] reg_h;

    // Address decode: a write strobe selects at most one byte register.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path leaves it unassigned and no latch is inferred.
        sel_low  = 1'b0;
        sel_high = 1'b0;
        if (BUS_WE) begin
            sel_low  = (BUS_ADDR == BASE_ADDR);
            sel_high = (BUS_ADDR == HIGH_ADDR) && !sel_low;
        end
    end

    // Byte registers: reset wins over a simultaneous write; otherwise the
    // addressed byte takes the bus data and the other byte holds.
    always_ff @(posedge CLK) begin
        // NOTE: state is updated with non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!RESET) begin
            reg_l <= 8'h00;
            reg_h <= 8'h00;
        end else if (sel_low) begin
            reg_l <= BUS_DATA;
        end else if (sel_high) begin
            reg_h <= BUS_DATA;
        end
    end

    // Outputs come straight from the flops: no combinational path from the bus.
    assign LEDL = reg_l;
    assign LEDH = reg_h;

endmodule

// File: tb/tb_led.sv
// Self-checking bench for led: a directed vector table, hand-written
// multi-cycle sequences, and randomized traffic checked against a
// behavioural model. A second instance at BASE_ADDR 8'hFF exercises the
// address wrap of the high-byte register.
module tb_led;

    logic       CLK;
    logic       RESET;
    logic [7:0] BUS_ADDR;
    logic [7:0] BUS_DATA;
    logic       BUS_WE;
    logic [7:0] LEDH;
    logic [7:0] LEDL;
    logic [7:0] wrap_h;
    logic [7:0] wrap_l;

    int n_checks = 0;
    int n_fail   = 0;

    led #(.BASE_ADDR(8'hC0)) u_dut (
        .CLK(CLK), .RESET(RESET), .BUS_ADDR(BUS_ADDR), .BUS_DATA(BUS_DATA),
        .BUS_WE(BUS_WE), .LEDH(LEDH), .LEDL(LEDL)
    );

    led #(.BASE_ADDR(8'hFF)) u_wrap (
        .CLK(CLK), .RESET(RESET), .BUS_ADDR(BUS_ADDR), .BUS_DATA(BUS_DATA),
        .BUS_WE(BUS_WE), .LEDH(wrap_h), .LEDL(wrap_l)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Behavioural model: per instance, a two-entry byte array indexed by the
    // address offset from that instance's base (8-bit arithmetic).
    logic [7:0] base_of [2] = '{8'hC0, 8'hFF};
    logic [7:0] mdl [2][2];
    bit         mdl_valid = 1'b0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input logic rst_n, input logic we,
                                input logic [7:0] addr, input logic [7:0] data);
        logic [7:0] off;
        for (int b = 0; b < 2; b++) begin
            if (!rst_n) begin
                mdl[b][0] = 8'h00;
                mdl[b][1] = 8'h00;
            end else if (we) begin
                off = addr - base_of[b];
                if (off < 8'd2) mdl[b][off[0]] = data;
            end
        end
        if (!rst_n) mdl_valid = 1'b1;
    endtask

    // Apply one bus cycle, clock it, then compare both instances with the model
    // #1 after the edge.
    task automatic step(input logic rst_n, input logic we,
                        input logic [7:0] addr, input logic [7:0] data,
                        input bit model_chk);
        RESET    = rst_n;
        BUS_WE   = we;
        BUS_ADDR = addr;
        BUS_DATA = data;
        model_update(rst_n, we, addr, data);
        @(posedge CLK);
        #1;
        if (model_chk && mdl_valid) begin
            check("model_ledl", LEDL,   mdl[0][0]);
            check("model_ledh", LEDH,   mdl[0][1]);
            check("wrap_ledl",  wrap_l, mdl[1][0]);
            check("wrap_ledh",  wrap_h, mdl[1][1]);
        end
    endtask

    typedef struct {
        logic       rst_n;
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp_l;
        logic [7:0] exp_h;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [7:0] addr_pick [7];
        logic [7:0] a;

        RESET    = 1'b1;
        BUS_WE   = 1'b0;
        BUS_ADDR = 8'hFF;
        BUS_DATA = 8'h00;

        // Directed vectors; expectations are absolute values for the C0 instance.
        vecs[0]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h00}; // release reset
        vecs[1]  = '{1'b1, 1'b1, 8'hC0, 8'hFF, 8'hFF, 8'h00}; // low write
        vecs[2]  = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'hFF, 8'h00}; // idle hold
        vecs[3]  = '{1'b1, 1'b1, 8'hC1, 8'hF0, 8'hFF, 8'hF0}; // high write
        vecs[4]  = '{1'b1, 1'b1, 8'hC2, 8'h55, 8'hFF, 8'hF0}; // other address
        vecs[5]  = '{1'b1, 1'b0, 8'hC0, 8'h00, 8'hFF, 8'hF0}; // read at C0
        vecs[6]  = '{1'b1, 1'b1, 8'hFF, 8'hAA, 8'hFF, 8'hF0}; // write to idle addr
        vecs[7]  = '{1'b1, 1'b1, 8'hBF, 8'h11, 8'hFF, 8'hF0}; // just below base
        vecs[8]  = '{1'b1, 1'b1, 8'hC0, 8'h12, 8'h12, 8'hF0}; // back-to-back 1
        vecs[9]  = '{1'b1, 1'b1, 8'hC0, 8'h34, 8'h34, 8'hF0}; // back-to-back 2
        vecs[10] = '{1'b1, 1'b1, 8'hC1, 8'hAB, 8'h34, 8'hAB}; // back-to-back 3
        vecs[11] = '{1'b0, 1'b1, 8'hC0, 8'h77, 8'h00, 8'h00}; // reset collision
        vecs[12] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h00, 8'h00}; // stays cleared

        // Reset held for 10 cycles on the idle address.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'hFF, 8'h00, 1'b1);
        check("reset_ledl", LEDL, 8'h00);
        check("reset_ledh", LEDH, 8'h00);

        for (int i = 0; i < 4; i++) begin
            step(vecs[i].rst_n, vecs[i].we, vecs[i].addr, vecs[i].data, 1'b1);
            check($sformatf("vec%0d_ledl", i), LEDL, vecs[i].exp_l);
            check($sformatf("vec%0d_ledh", i), LEDH, vecs[i].exp_h);
        end

        // Long idle hold after the high write, with junk on the bus while WE=0.
        for (int i = 0; i < 10000; i++)
            step(1'b1, 1'b0, 8'($urandom), 8'($urandom), 1'b0);
        check("hold_ledl", LEDL, 8'hFF);
        check("hold_ledh", LEDH, 8'hF0);

        for (int i = 4; i < 13; i++) begin
            step(vecs[i].rst_n, vecs[i].we, vecs[i].addr, vecs[i].data, 1'b1);
            check($sformatf("vec%0d_ledl", i), LEDL, vecs[i].exp_l);
            check($sformatf("vec%0d_ledh", i), LEDH, vecs[i].exp_h);
        end

        // Wrap instance: FF is its low byte, 00 its high byte.
        step(1'b1, 1'b1, 8'hFF, 8'h5A, 1'b1);
        step(1'b1, 1'b1, 8'h00, 8'hC3, 1'b1);
        check("wrap_low_ff",  wrap_l, 8'h5A);
        check("wrap_high_00", wrap_h, 8'hC3);
        check("main_untouched_l", LEDL, 8'h00);
        check("main_untouched_h", LEDH, 8'h00);

        // Reset held low across several write cycles keeps everything cleared.
        step(1'b1, 1'b1, 8'hC0, 8'h9C, 1'b1);
        step(1'b1, 1'b1, 8'hC1, 8'h3E, 1'b1);
        check("pre_reset_l", LEDL, 8'h9C);
        check("pre_reset_h", LEDH, 8'h3E);
        step(1'b0, 1'b1, 8'hC1, 8'h01, 1'b1);
        step(1'b0, 1'b1, 8'hC0, 8'h02, 1'b1);
        step(1'b0, 1'b1, 8'hFF, 8'h03, 1'b1);
        check("held_reset_l", LEDL, 8'h00);
        check("held_reset_h", LEDH, 8'h00);
        check("held_reset_wl", wrap_l, 8'h00);
        check("held_reset_wh", wrap_h, 8'h00);

        // Randomized traffic, concentrated on the interesting addresses.
        addr_pick = '{8'hC0, 8'hC1, 8'hC2, 8'hBF, 8'hFF, 8'h00, 8'h01};
        for (int i = 0; i < 3000; i++) begin
            a = ($urandom_range(0, 7) == 7) ? 8'($urandom) : addr_pick[$urandom_range(0, 6)];
            step(($urandom_range(0, 24) != 0), 1'($urandom), a, 8'($urandom), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
